// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Shared types and constants for the unified-memory port arbiter.
// Rev    : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } arb_port_t;

    localparam int RD_LAT_MAX = 4;
    localparam int c_RD_CNT_W = $clog2(RD_LAT_MAX);

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter_if
// Brief  : CPU, debug and memory-side signal bundle of the port arbiter.
// Rev    : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_grant
// Brief  : Combinational winner selection between CPU and debug requests.
//          MEM_ARB_DBG_PRIO_EN selects fixed debug priority over round-robin.
// Rev    : 1.0
// ============================================================================
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic      i_cpu_req,
    input  logic      i_dbg_req,
    input  arb_port_t i_last_grant,
    output logic      o_any,
    output arb_port_t o_winner
);

    assign o_any = i_cpu_req | i_dbg_req;

`ifdef MEM_ARB_DBG_PRIO_EN
    logic w_unused_last_grant;
    assign w_unused_last_grant = (i_last_grant == PORT_DBG);

    always_comb begin
        o_winner = i_dbg_req ? PORT_DBG : PORT_CPU;
    end
`else
    // On a tie the port that did not win last time goes next.
    always_comb begin
        o_winner = PORT_CPU;
        if (i_cpu_req && i_dbg_req)
            o_winner = (i_last_grant == PORT_DBG) ? PORT_CPU : PORT_DBG;
        else if (i_dbg_req)
            o_winner = PORT_DBG;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Serialises CPU and debug accesses onto one memory with a fixed
//          read latency. MEM_ARB_DBG_PRIO_EN gives debug fixed priority.
// Rev    : 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [c_RD_CNT_W-1:0] c_CNT_LOAD = c_RD_CNT_W'(RD_LAT - 1);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    arb_port_t               r_owner;
    arb_port_t               r_last_grant;
    arb_port_t               w_winner;
    logic                    w_any;
    logic                    w_take;
    logic                    w_capture;
    logic [c_RD_CNT_W-1:0]   r_cnt;
    logic [c_RD_CNT_W-1:0]   w_cnt_nxt;
    logic                    r_mem_we;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [DATA_W-1:0]       r_mem_wdata;
    logic [DATA_W-1:0]       r_cpu_rdata;
    logic [DATA_W-1:0]       r_dbg_rdata;

    mem_arb_grant u_grant (
        .i_cpu_req    (bus.cpu_req),
        .i_dbg_req    (bus.dbg_req),
        .i_last_grant (r_last_grant),
        .o_any        (w_any),
        .o_winner     (w_winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_take      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_take      = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (r_mem_we) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt   = c_CNT_LOAD;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request fields are latched at grant so the memory sees stable values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= PORT_CPU;
            r_last_grant <= PORT_DBG;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            if (w_take) begin
                r_owner      <= w_winner;
                r_last_grant <= w_winner;
                if (w_winner == PORT_DBG) begin
                    r_mem_we    <= bus.dbg_we;
                    r_mem_addr  <= bus.dbg_addr;
                    r_mem_wdata <= bus.dbg_wdata;
                end else begin
                    r_mem_we    <= bus.cpu_we;
                    r_mem_addr  <= bus.cpu_addr;
                    r_mem_wdata <= bus.cpu_wdata;
                end
            end
            if (w_capture) begin
                if (r_owner == PORT_DBG)
                    r_dbg_rdata <= bus.mem_rdata;
                else
                    r_cpu_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = (r_state == ISSUE);
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.dbg_rdata = r_dbg_rdata;
    assign bus.cpu_ack   = (r_state == RESP) && (r_owner == PORT_CPU);
    assign bus.dbg_ack   = (r_state == RESP) && (r_owner == PORT_DBG);

endmodule
`default_nettype wire
